// File: rtl/button_debouncer.sv
// Push-button front end: synchronises and debounces N raw buttons and
// emits clean levels plus one-clk press, release and long-press pulses.
module button_debouncer #(
    parameter int unsigned N_BUTTONS     = 1,
    parameter int unsigned PRESCALE_BITS = 12,
    parameter int unsigned STABLE_TICKS  = 15,
    parameter int unsigned LONG_TICKS    = 762,
    parameter bit          ACTIVE_LOW    = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_BUTTONS-1:0] btn_raw,
    output logic [N_BUTTONS-1:0] btn_level,
    output logic [N_BUTTONS-1:0] btn_press,
    output logic [N_BUTTONS-1:0] btn_release,
    output logic [N_BUTTONS-1:0] btn_long
);

    localparam int unsigned CNT_W  = $clog2(STABLE_TICKS + 1);
    localparam int unsigned HOLD_W = $clog2(LONG_TICKS + 1);

    localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(STABLE_TICKS - 1);
    localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(LONG_TICKS - 1);
    localparam logic [HOLD_W-1:0]    HOLD_MAX  = HOLD_W'(LONG_TICKS);
    localparam logic [N_BUTTONS-1:0] RELEASED  = {N_BUTTONS{ACTIVE_LOW}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHK_PRS = 2'd1,
        PRESSED = 2'd2,
        CHK_REL = 2'd3
    } state_t;

    logic [N_BUTTONS-1:0]     sync1;
    logic [N_BUTTONS-1:0]     sync2;
    logic [N_BUTTONS-1:0]     s_c;
    logic [PRESCALE_BITS-1:0] presc;
    logic                     tick_c;

    state_t            state   [N_BUTTONS];
    state_t            state_d [N_BUTTONS];
    logic [CNT_W-1:0]  cnt     [N_BUTTONS];
    logic [CNT_W-1:0]  cnt_d   [N_BUTTONS];
    logic [HOLD_W-1:0] hold    [N_BUTTONS];
    logic [HOLD_W-1:0] hold_d  [N_BUTTONS];

    logic [N_BUTTONS-1:0] level_d;
    logic [N_BUTTONS-1:0] press_d;
    logic [N_BUTTONS-1:0] release_d;
    logic [N_BUTTONS-1:0] long_d;

    // Polarity-normalised synchronised inputs: 1 = pressed
    assign s_c    = ACTIVE_LOW ? ~sync2 : sync2;
    assign tick_c = &presc;

    // Synchroniser, prescaler, per-channel state and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1       <= RELEASED;
            sync2       <= RELEASED;
            presc       <= '0;
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            btn_long    <= '0;
            for (int i = 0; i < int'(N_BUTTONS); i++) begin
                state[i] <= IDLE;
                cnt[i]   <= '0;
                hold[i]  <= '0;
            end
        end else begin
            sync1       <= btn_raw;
            sync2       <= sync1;
            presc       <= presc + PRESCALE_BITS'(1);
            btn_level   <= level_d;
            btn_press   <= press_d;
            btn_release <= release_d;
            btn_long    <= long_d;
            for (int i = 0; i < int'(N_BUTTONS); i++) begin
                state[i] <= state_d[i];
                cnt[i]   <= cnt_d[i];
                hold[i]  <= hold_d[i];
            end
        end
    end

    // Per-channel debounce FSM; everything advances only on tick cycles
    always_comb begin
        for (int i = 0; i < int'(N_BUTTONS); i++) begin
            state_d[i]   = state[i];
            cnt_d[i]     = cnt[i];
            hold_d[i]    = hold[i];
            press_d[i]   = 1'b0;
            release_d[i] = 1'b0;
            long_d[i]    = 1'b0;

            if (tick_c) begin
                case (state[i])
                    IDLE: begin
                        if (s_c[i]) begin
                            if (STABLE_TICKS == 1) begin
                                state_d[i] = PRESSED;
                                press_d[i] = 1'b1;
                                hold_d[i]  = '0;
                                cnt_d[i]   = '0;
                            end else begin
                                state_d[i] = CHK_PRS;
                                cnt_d[i]   = CNT_W'(1);
                            end
                        end
                    end
                    CHK_PRS: begin
                        if (!s_c[i]) begin
                            state_d[i] = IDLE;
                            cnt_d[i]   = '0;
                        end else if (cnt[i] == CNT_LAST) begin
                            state_d[i] = PRESSED;
                            press_d[i] = 1'b1;
                            hold_d[i]  = '0;
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i] = cnt[i] + CNT_W'(1);
                        end
                    end
                    PRESSED: begin
                        if (!s_c[i]) begin
                            if (STABLE_TICKS == 1) begin
                                state_d[i]   = IDLE;
                                release_d[i] = 1'b1;
                                hold_d[i]    = '0;
                                cnt_d[i]     = '0;
                            end else begin
                                state_d[i] = CHK_REL;
                                cnt_d[i]   = CNT_W'(1);
                            end
                        end else if (hold[i] != HOLD_MAX) begin
                            // Saturation makes the LAST->MAX step happen once per press
                            hold_d[i] = hold[i] + HOLD_W'(1);
                            long_d[i] = (hold[i] == HOLD_LAST);
                        end
                    end
                    CHK_REL: begin
                        if (s_c[i]) begin
                            state_d[i] = PRESSED;
                            cnt_d[i]   = '0;
                        end else if (cnt[i] == CNT_LAST) begin
                            state_d[i]   = IDLE;
                            release_d[i] = 1'b1;
                            hold_d[i]    = '0;
                            cnt_d[i]     = '0;
                        end else begin
                            cnt_d[i] = cnt[i] + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                        hold_d[i]  = '0;
                    end
                endcase
            end

            level_d[i] = (state_d[i] == PRESSED) || (state_d[i] == CHK_REL);
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: two channels, PRESCALE_BITS=2,
// STABLE_TICKS=3, LONG_TICKS=5, active-low buttons; cyc counts edges since reset.
module tb_button_debouncer;

    logic       clk;
    logic       rst_n;
    logic [1:0] btn_raw;
    logic [1:0] btn_level;
    logic [1:0] btn_press;
    logic [1:0] btn_release;
    logic [1:0] btn_long;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    button_debouncer #(
        .N_BUTTONS    (2),
        .PRESCALE_BITS(2),
        .STABLE_TICKS (3),
        .LONG_TICKS   (5),
        .ACTIVE_LOW   (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_long   (btn_long)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [1:0] el, input logic [1:0] ep,
                       input logic [1:0] er, input logic [1:0] elg);
        vectors++;
        assert (btn_level === el) else begin
            miscompares++;
            $error("FAIL %s level cyc=%0d got %b exp %b", tag, cyc, btn_level, el);
        end
        vectors++;
        assert (btn_press === ep) else begin
            miscompares++;
            $error("FAIL %s press cyc=%0d got %b exp %b", tag, cyc, btn_press, ep);
        end
        vectors++;
        assert (btn_release === er) else begin
            miscompares++;
            $error("FAIL %s release cyc=%0d got %b exp %b", tag, cyc, btn_release, er);
        end
        vectors++;
        assert (btn_long === elg) else begin
            miscompares++;
            $error("FAIL %s long cyc=%0d got %b exp %b", tag, cyc, btn_long, elg);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        btn_raw = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
        chk("reset", 2'b00, 2'b00, 2'b00, 2'b00);

        // Idle with buttons released
        while (cyc < 40) begin
            step();
            chk("idle", 2'b00, 2'b00, 2'b00, 2'b00);
        end

        // Clean press on channel 0: ticks at 44,48,52 -> commit at 52
        btn_raw[0] = 1'b0;
        while (cyc < 60) begin
            step();
            chk("press", {1'b0, cyc >= 52}, {1'b0, cyc == 52}, 2'b00, 2'b00);
        end

        // Held: long pulse 5 ticks after commit (cyc 72), never again
        while (cyc < 172) begin
            step();
            chk("hold", 2'b01, 2'b00, 2'b00, {1'b0, cyc == 72});
        end

        // Release: ticks 176,180,184 -> release at 184
        btn_raw[0] = 1'b1;
        while (cyc < 190) begin
            step();
            chk("release", {1'b0, cyc < 184}, 2'b00, {1'b0, cyc == 184}, 2'b00);
        end

        // Bounce every 3 clk: never 3 agreeing ticks in a row
        while (cyc < 280) begin
            if (cyc < 250 && (cyc - 190) % 3 == 0)
                btn_raw[0] = (((cyc - 190) / 3) % 2 == 0) ? 1'b0 : 1'b1;
            else if (cyc == 250)
                btn_raw[0] = 1'b1;
            step();
            chk("bounce", 2'b00, 2'b00, 2'b00, 2'b00);
        end

        // Clean press on [0] while [1] bounces; long on [0] at 312
        btn_raw[0] = 1'b0;
        while (cyc < 330) begin
            if (cyc < 316 && (cyc - 280) % 3 == 0)
                btn_raw[1] = (((cyc - 280) / 3) % 2 == 0) ? 1'b0 : 1'b1;
            else if (cyc == 316)
                btn_raw[1] = 1'b1;
            step();
            chk("indep", {1'b0, cyc >= 292}, {1'b0, cyc == 292}, 2'b00, {1'b0, cyc == 312});
        end

        btn_raw[0] = 1'b1;
        while (cyc < 350) begin
            step();
            chk("rel0", {1'b0, cyc < 344}, 2'b00, {1'b0, cyc == 344}, 2'b00);
        end

        // Both pressed together: simultaneous commit at 364
        btn_raw = 2'b00;
        while (cyc < 375) begin
            step();
            chk("both", (cyc >= 364) ? 2'b11 : 2'b00, (cyc == 364) ? 2'b11 : 2'b00,
                2'b00, 2'b00);
        end

        // One-clk reset while pressed; buttons remain held
        rst_n = 1'b0;
        step();
        chk("midreset", 2'b00, 2'b00, 2'b00, 2'b00);
        rst_n = 1'b1;

        // Ticks at 380,384,388 -> re-press at 388, no release, no stale long
        while (cyc < 400) begin
            step();
            chk("repress", (cyc >= 388) ? 2'b11 : 2'b00, (cyc == 388) ? 2'b11 : 2'b00,
                2'b00, 2'b00);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
